// File: rtl/fir_8_bit_pkg.sv
// Shared widths and types for the 8-tap unsigned FIR filter.
package fir_8_bit_pkg;

    localparam int unsigned N       = 8;
    localparam int unsigned TAPS    = 8;
    localparam int unsigned OUT_W   = N + 3;
    localparam int unsigned ACC_W   = 2 * N + 3;
    localparam int unsigned PROD_W  = 2 * N;
    localparam logic [OUT_W-1:0] SAT_MAX = '1;

    // Index 0 holds the newest sample / the coefficient for x[n].
    typedef logic [TAPS-1:0][N-1:0] window_t;
    typedef logic [TAPS-2:0][N-1:0] history_t;

endpackage

// File: rtl/fir_8_bit_tap_sum.sv
// Combinational multiply-accumulate over the tap window with output saturation.
module fir_8_bit_tap_sum
    import fir_8_bit_pkg::*;
(
    input  window_t            window_i,
    input  window_t            coeffs_i,
    output logic [OUT_W-1:0]   sum_o
);

    logic [ACC_W-1:0]  acc;
    logic [PROD_W-1:0] prod;

    always_comb begin
        acc  = '0;
        prod = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            prod = {{N{1'b0}}, window_i[k]} * {{N{1'b0}}, coeffs_i[k]};
            acc  = acc + ACC_W'(prod);
        end
        if (acc > ACC_W'(SAT_MAX)) begin
            sum_o = SAT_MAX;
        end else begin
            sum_o = acc[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fir_8_bit.sv
// 8-tap direct-form FIR: delay line, registered output and valid/busy handshake.
module fir_8_bit
    import fir_8_bit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       coeffs_table_0,
    input  logic [N-1:0]       coeffs_table_1,
    input  logic [N-1:0]       coeffs_table_2,
    input  logic [N-1:0]       coeffs_table_3,
    input  logic [N-1:0]       coeffs_table_4,
    input  logic [N-1:0]       coeffs_table_5,
    input  logic [N-1:0]       coeffs_table_6,
    input  logic [N-1:0]       coeffs_table_7,
    input  logic [N-1:0]       din_data,
    input  logic               din_vld,
    input  logic               dout_busy,
    output logic [OUT_W-1:0]   dout_data,
    output logic               dout_vld
);

    // The oldest tap x[7] is overwritten on every shift before it is read again,
    // so only x[0..6] are stored; the post-shift window is rebuilt from them.
    history_t          hist_q, hist_d;
    logic [OUT_W-1:0]  dout_data_q, dout_data_d;
    logic              dout_vld_q, dout_vld_d;

    window_t           win_next;
    window_t           coeffs;
    logic [OUT_W-1:0]  sum;
    logic              stall;
    logic              accept;

    assign coeffs = {coeffs_table_7, coeffs_table_6, coeffs_table_5, coeffs_table_4,
                     coeffs_table_3, coeffs_table_2, coeffs_table_1, coeffs_table_0};
    assign win_next = {hist_q, din_data};

    fir_8_bit_tap_sum u_tap_sum (
        .window_i (win_next),
        .coeffs_i (coeffs),
        .sum_o    (sum)
    );

    always_comb begin
        stall       = dout_vld_q & dout_busy;
        accept      = din_vld & ~stall;
        hist_d      = hist_q;
        dout_data_d = dout_data_q;
        dout_vld_d  = dout_vld_q;
        if (accept) begin
            hist_d      = win_next[TAPS-2:0];
            dout_data_d = sum;
            dout_vld_d  = 1'b1;
        end else if (!stall) begin
            dout_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q      <= '0;
            dout_data_q <= '0;
            dout_vld_q  <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            dout_data_q <= dout_data_d;
            dout_vld_q  <= dout_vld_d;
        end
    end

    assign dout_data = dout_data_q;
    assign dout_vld  = dout_vld_q;

endmodule

// File: tb/tb_fir_8_bit.sv
// Directed-vector bench for fir_8_bit with hand-computed expected outputs.
module tb_fir_8_bit;

    logic        clk;
    logic        rst;
    logic [7:0]  coef [8];
    logic [7:0]  din_data;
    logic        din_vld;
    logic        dout_busy;
    logic [10:0] dout_data;
    logic        dout_vld;

    int vectors;
    int miscompares;

    fir_8_bit dut (
        .clk            (clk),
        .rst            (rst),
        .coeffs_table_0 (coef[0]),
        .coeffs_table_1 (coef[1]),
        .coeffs_table_2 (coef[2]),
        .coeffs_table_3 (coef[3]),
        .coeffs_table_4 (coef[4]),
        .coeffs_table_5 (coef[5]),
        .coeffs_table_6 (coef[6]),
        .coeffs_table_7 (coef[7]),
        .din_data       (din_data),
        .din_vld        (din_vld),
        .dout_busy      (dout_busy),
        .dout_data      (dout_data),
        .dout_vld       (dout_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one input for one rising edge, then settle 1 time unit past it.
    task automatic step(input logic [7:0] d, input logic v);
        din_data = d;
        din_vld  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 8; i++) coef[i] = v;
    endtask

    task automatic do_reset();
        din_vld   = 1'b0;
        din_data  = '0;
        dout_busy = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din_vld = 1'b0;
        din_data = '0;
        dout_busy = 1'b0;
        set_all(8'd0);
        #3;
        vectors++;
        if (dout_vld !== 1'b0 || dout_data !== 11'd0) begin
            miscompares++;
            $display("FAIL reset: vld=%b data=%0d required vld=0 data=0", dout_vld, dout_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(8'd0, 1'b0);
        vectors++;
        if (dout_vld !== 1'b0 || dout_data !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_idle: vld=%b data=%0d required vld=0 data=0", dout_vld, dout_data);
        end
    endtask

    task automatic test_impulse();
        logic [7:0]  din_v [3];
        logic [10:0] exp_v;
        din_v = '{8'd5, 8'd7, 8'd9};
        do_reset();
        set_all(8'd0);
        coef[0] = 8'd1;
        for (int i = 0; i < 3; i++) begin
            step(din_v[i], 1'b1);
            vectors++;
            if (dout_vld !== 1'b1 || dout_data !== 11'(din_v[i])) begin
                miscompares++;
                $display("FAIL order[%0d]: vld=%b data=%0d required vld=1 data=%0d",
                         i, dout_vld, dout_data, din_v[i]);
            end
        end
        do_reset();
        set_all(8'd0);
        coef[7] = 8'd1;
        for (int i = 0; i < 8; i++) begin
            step((i == 0) ? 8'd1 : 8'd0, 1'b1);
            exp_v = (i == 7) ? 11'd1 : 11'd0;
            vectors++;
            if (dout_vld !== 1'b1 || dout_data !== exp_v) begin
                miscompares++;
                $display("FAIL impulse_tap7[%0d]: vld=%b data=%0d required vld=1 data=%0d",
                         i, dout_vld, dout_data, exp_v);
            end
        end
        step(8'd0, 1'b0);
    endtask

    task automatic test_moving_sum();
        logic [7:0]  din_v [10];
        logic [10:0] exp_v [10];
        din_v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd5, 8'd0, 8'd0};
        exp_v = '{11'd1, 11'd3, 11'd6, 11'd10, 11'd15, 11'd21, 11'd28, 11'd33, 11'd32, 11'd30};
        do_reset();
        set_all(8'd1);
        for (int i = 0; i < 10; i++) begin
            step(din_v[i], 1'b1);
            vectors++;
            if (dout_vld !== 1'b1 || dout_data !== exp_v[i]) begin
                miscompares++;
                $display("FAIL moving_sum[%0d]: vld=%b data=%0d required vld=1 data=%0d",
                         i, dout_vld, dout_data, exp_v[i]);
            end
        end
        step(8'd0, 1'b0);
    endtask

    task automatic test_back_pressure();
        do_reset();
        set_all(8'd1);
        step(8'd1, 1'b1);
        dout_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(8'd2, 1'b1);
            vectors++;
            if (dout_vld !== 1'b1 || dout_data !== 11'd1) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: vld=%b data=%0d required vld=1 data=1",
                         i, dout_vld, dout_data);
            end
        end
        dout_busy = 1'b0;
        step(8'd2, 1'b1);
        vectors++;
        if (dout_vld !== 1'b1 || dout_data !== 11'd3) begin
            miscompares++;
            $display("FAIL stall_release: vld=%b data=%0d required vld=1 data=3", dout_vld, dout_data);
        end
        step(8'd0, 1'b0);
    endtask

    task automatic test_saturation();
        logic [10:0] exp_v;
        do_reset();
        set_all(8'd255);
        for (int i = 0; i < 8; i++) begin
            step(8'd255, 1'b1);
            vectors++;
            if (dout_data !== 11'd2047) begin
                miscompares++;
                $display("FAIL sat_max[%0d]: data=%0d required 2047", i, dout_data);
            end
        end
        do_reset();
        set_all(8'd1);
        for (int i = 0; i < 8; i++) begin
            step(8'd255, 1'b1);
            exp_v = 11'(255 * (i + 1));
            vectors++;
            if (dout_data !== exp_v) begin
                miscompares++;
                $display("FAIL sat_none[%0d]: data=%0d required %0d", i, dout_data, exp_v);
            end
        end
        do_reset();
        set_all(8'd0);
        coef[0] = 8'd23;
        step(8'd89, 1'b1);
        vectors++;
        if (dout_data !== 11'd2047) begin
            miscompares++;
            $display("FAIL sat_exact_2047: data=%0d required 2047", dout_data);
        end
        do_reset();
        set_all(8'd0);
        coef[0] = 8'd16;
        coef[1] = 8'd1;
        step(8'd1, 1'b1);
        step(8'd128, 1'b1);
        vectors++;
        if (dout_data !== 11'd2047) begin
            miscompares++;
            $display("FAIL sat_2049: data=%0d required 2047", dout_data);
        end
        step(8'd0, 1'b0);
    endtask

    task automatic test_coeff_change();
        do_reset();
        set_all(8'd1);
        step(8'd2, 1'b1);
        step(8'd3, 1'b1);
        set_all(8'd0);
        coef[1] = 8'd2;
        step(8'd5, 1'b1);
        vectors++;
        if (dout_data !== 11'd6) begin
            miscompares++;
            $display("FAIL coeff_change: data=%0d required 6", dout_data);
        end
        step(8'd0, 1'b0);
    endtask

    task automatic test_drain();
        do_reset();
        set_all(8'd1);
        step(8'd3, 1'b1);
        vectors++;
        if (dout_vld !== 1'b1 || dout_data !== 11'd3) begin
            miscompares++;
            $display("FAIL drain_out: vld=%b data=%0d required vld=1 data=3", dout_vld, dout_data);
        end
        for (int i = 0; i < 2; i++) begin
            step(8'd7, 1'b0);
            vectors++;
            if (dout_vld !== 1'b0 || dout_data !== 11'd3) begin
                miscompares++;
                $display("FAIL drain_idle[%0d]: vld=%b data=%0d required vld=0 data=3",
                         i, dout_vld, dout_data);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_all(8'd1);
        step(8'd9, 1'b1);
        din_vld = 1'b0;
        vectors++;
        if (dout_vld !== 1'b1 || dout_data !== 11'd9) begin
            miscompares++;
            $display("FAIL pre_async: vld=%b data=%0d required vld=1 data=9", dout_vld, dout_data);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (dout_vld !== 1'b0 || dout_data !== 11'd0) begin
            miscompares++;
            $display("FAIL async_clear: vld=%b data=%0d required vld=0 data=0", dout_vld, dout_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(8'd4, 1'b1);
        vectors++;
        if (dout_vld !== 1'b1 || dout_data !== 11'd4) begin
            miscompares++;
            $display("FAIL post_async: vld=%b data=%0d required vld=1 data=4", dout_vld, dout_data);
        end
        step(8'd0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_impulse();
        test_moving_sum();
        test_back_pressure();
        test_saturation();
        test_coeff_change();
        test_drain();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
